// File: rtl/mem_access_unit.sv
// Load/store unit between a request/response handshake and a doubleword-wide data memory.
// Partial stores use read-modify-write. Misaligned or out-of-range accesses answer with an error and never touch memory.
module mem_access_unit #(
    parameter int SIZE = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [63:0] mem_address,
    output logic [63:0] mem_indata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_outread
);

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t      state, next_state;
    logic        op_write, op_signed;
    logic [1:0]  op_size;
    logic [2:0]  op_offset;
    logic [63:0] op_wdata;
    logic        accept, req_misaligned, req_out_of_range, req_err;
    logic [5:0]  shift;
    logic [63:0] size_mask, lane_mask, lane_data, load_data, merged_data;

    function automatic logic [63:0] mask_for(input logic [1:0] sz);
        case (sz)
            2'b00:   return 64'h0000_0000_0000_00FF;
            2'b01:   return 64'h0000_0000_0000_FFFF;
            2'b10:   return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // An access is aligned when the address bits below its size are all zero.
    always_comb begin
        req_misaligned = 1'b0;
        case (req_size)
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = |req_addr[1:0];
            2'b11:   req_misaligned = |req_addr[2:0];
            default: req_misaligned = 1'b0;
        endcase
    end

    assign req_out_of_range = req_addr[63:3] >= 61'(SIZE);
    assign req_err          = req_misaligned | req_out_of_range;
    assign accept           = req_valid & req_ready;

    assign shift       = {op_offset, 3'b000};
    assign size_mask   = mask_for(op_size);
    assign lane_mask   = size_mask << shift;
    assign lane_data   = (mem_outread >> shift) & size_mask;
    assign merged_data = (mem_outread & ~lane_mask) | ((op_wdata & size_mask) << shift);

    always_comb begin
        load_data = lane_data;
        if (op_signed) begin
            case (op_size)
                2'b00:   load_data = {{56{lane_data[7]}}, lane_data[7:0]};
                2'b01:   load_data = {{48{lane_data[15]}}, lane_data[15:0]};
                2'b10:   load_data = {{32{lane_data[31]}}, lane_data[31:0]};
                default: load_data = lane_data;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // A partial store reads first, so it goes RD then WR. A doubleword store goes straight to WR.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                                next_state = RSP;
                    else if (req_write && req_size == 2'b11)    next_state = WR;
                    else                                        next_state = RD;
                end
            end
            RD: begin
                mem_read   = 1'b1;
                next_state = op_write ? WR : RSP;
            end
            WR: begin
                mem_write  = 1'b1;
                next_state = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The memory address and write data are registers. They keep their last values while the unit is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_write    <= 1'b0;
            op_signed   <= 1'b0;
            op_size     <= 2'b00;
            op_offset   <= 3'b000;
            op_wdata    <= '0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            mem_address <= '0;
            mem_indata  <= '0;
        end else begin
            if (accept) begin
                op_write  <= req_write;
                op_signed <= req_signed;
                op_size   <= req_size;
                op_offset <= req_addr[2:0];
                op_wdata  <= req_wdata;
                rsp_err   <= req_err;
                rsp_rdata <= '0;
                if (!req_err) begin
                    mem_address <= {3'b000, req_addr[63:3]};
                    if (req_write && req_size == 2'b11) mem_indata <= req_wdata;
                end
            end
            if (state == RD) begin
                if (op_write) mem_indata <= merged_data;
                else          rsp_rdata  <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit.
// It uses a byte-level reference memory and a behavioural data memory attached to the unit.
module tb_mem_access_unit;

    localparam int SIZE = 32;
    localparam int AW   = $clog2(SIZE);

    logic        clk, reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata, mem_address, mem_indata, mem_outread;
    logic        mem_write, mem_read, mem_init;

    logic [63:0] tbmem   [SIZE];
    logic [63:0] ref_mem [SIZE];

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          rds;
        int          wrs;
        logic [63:0] idx;
        int          acc_cyc;
    } exp_t;

    exp_t        q[$];
    int          tests, fails, cyc;
    int          rd_cnt, wr_cnt, stall_left;
    bit          first_seen, monitor_en, hold_next, rand_ready;
    logic [63:0] last_rdata;

    mem_access_unit #(.SIZE(SIZE)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_address(mem_address),
        .mem_indata(mem_indata), .mem_write(mem_write), .mem_read(mem_read),
        .mem_outread(mem_outread)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: combinational read, synchronous write, preloaded with entry j = j.
    always_comb mem_outread = tbmem[mem_address[AW-1:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int j = 0; j < SIZE; j++) tbmem[j] <= 64'(j);
        end else if (mem_write) begin
            tbmem[mem_address[AW-1:0]] <= mem_indata;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // The reference works byte by byte on a plain array, following the access rules directly.
    function automatic exp_t refModel(input bit wr, input logic [1:0] sz, input bit sg,
                                      input logic [63:0] addr, input logic [63:0] wd);
        exp_t        e;
        int          n, off, ix;
        logic [63:0] val;
        n = 1 << sz;
        off = int'(addr % 8);
        e = '{rdata: '0, err: 1'b0, lat: 0, rds: 0, wrs: 0, idx: addr >> 3, acc_cyc: 0};
        if ((addr % 64'(n)) != 0 || (addr >> 3) >= 64'(SIZE)) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        ix = int'(addr >> 3);
        if (!wr) begin
            val = '0;
            for (int b = 0; b < n; b++) val[8*b +: 8] = ref_mem[ix][8*(off+b) +: 8];
            if (sg && n < 8 && val[8*n-1])
                for (int b = n; b < 8; b++) val[8*b +: 8] = 8'hFF;
            e.rdata = val;
            e.lat = 2;
            e.rds = 1;
        end else begin
            for (int b = 0; b < n; b++) ref_mem[ix][8*(off+b) +: 8] = wd[8*b +: 8];
            e.wrs = 1;
            e.rds = (n < 8) ? 1 : 0;
            e.lat = (n < 8) ? 3 : 2;
        end
        return e;
    endfunction

    task automatic applyStimulus(input bit wr, input logic [1:0] sz, input bit sg,
                                 input logic [63:0] addr, input logic [63:0] wd);
        int   t;
        exp_t e;
        @(negedge clk);
        req_write = wr;
        req_size = sz;
        req_signed = sg;
        req_addr = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        e = refModel(wr, sz, sg, addr, wd);
        e.acc_cyc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) checkOutput("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    // Monitor: checks memory traffic and responses at each negedge, and drives rsp_ready.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (monitor_en) begin
                if (mem_read || mem_write) begin
                    if (mem_read) rd_cnt++;
                    if (mem_write) wr_cnt++;
                    if (q.size() == 0) checkOutput("spurious_mem", {62'd0, mem_read, mem_write}, 64'd0);
                    else               checkOutput("mem_address", mem_address, q[0].idx);
                end
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        checkOutput("spurious_rsp", 64'(rsp_valid), 64'd0);
                        rsp_ready = 1'b1;
                    end else begin
                        if (!first_seen) begin
                            first_seen = 1'b1;
                            checkOutput("latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
                            checkOutput("mem_reads", 64'(rd_cnt), 64'(q[0].rds));
                            checkOutput("mem_writes", 64'(wr_cnt), 64'(q[0].wrs));
                            stall_left = hold_next ? 3 : 0;
                            hold_next = 1'b0;
                        end
                        checkOutput("rsp_rdata", rsp_rdata, q[0].rdata);
                        checkOutput("rsp_err", 64'(rsp_err), 64'(q[0].err));
                        checkOutput("req_ready_in_rsp", 64'(req_ready), 64'd0);
                        if (stall_left > 0) begin
                            rsp_ready = 1'b0;
                            stall_left--;
                        end else begin
                            rsp_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                        end
                        if (rsp_ready) begin
                            last_rdata = rsp_rdata;
                            void'(q.pop_front());
                            first_seen = 1'b0;
                            rd_cnt = 0;
                            wr_cnt = 0;
                        end
                    end
                end else begin
                    rsp_ready = 1'(($urandom_range(0, 1)));
                end
            end
        end
    end

    initial begin
        tests = 0; fails = 0; cyc = 0;
        rd_cnt = 0; wr_cnt = 0; stall_left = 0;
        first_seen = 1'b0; hold_next = 1'b0; rand_ready = 1'b0; monitor_en = 1'b1;
        last_rdata = '0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        reset = 1'b0; mem_init = 1'b1;
        for (int j = 0; j < SIZE; j++) ref_mem[j] = 64'(j);

        #2 reset = 1'b1;
        #1;
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 64'd0);
        checkOutput("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
        checkOutput("rst_mem_address", mem_address, 64'd0);
        checkOutput("rst_mem_indata", mem_indata, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_init = 1'b0;
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);

        applyStimulus(1'b0, 2'b11, 1'b0, 64'h28, 64'd0);
        applyStimulus(1'b1, 2'b00, 1'b0, 64'h11, 64'h1234_5678_9ABC_DEAB);
        drain();
        checkOutput("byte_store_entry2", tbmem[2], 64'h0000_0000_0000_AB02);
        applyStimulus(1'b0, 2'b00, 1'b1, 64'h11, 64'd0);
        drain();
        checkOutput("signed_byte_load", last_rdata, 64'hFFFF_FFFF_FFFF_FFAB);
        applyStimulus(1'b0, 2'b00, 1'b0, 64'h11, 64'd0);
        drain();
        checkOutput("unsigned_byte_load", last_rdata, 64'h0000_0000_0000_00AB);
        applyStimulus(1'b0, 2'b01, 1'b0, 64'h03, 64'd0);
        applyStimulus(1'b0, 2'b11, 1'b0, 64'h100, 64'd0);
        drain();
        hold_next = 1'b1;
        applyStimulus(1'b0, 2'b11, 1'b0, 64'h28, 64'd0);
        drain();

        // Reset during the write phase of a word store must leave entry 1 untouched.
        monitor_en = 1'b0;
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 64'h08; req_wdata = 64'hDEAD_BEEF; req_valid = 1'b1;
        checkOutput("rst_mid_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 checkOutput("rst_mid_in_wr", 64'(mem_write), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_write_drop", 64'(mem_write), 64'd0);
        checkOutput("rst_mid_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_entry1", tbmem[1], 64'd1);
        checkOutput("rst_mid_ready_after", 64'(req_ready), 64'd1);
        q.delete();
        rd_cnt = 0; wr_cnt = 0; first_seen = 1'b0; stall_left = 0;
        monitor_en = 1'b1;

        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [63:0] a;
            if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
            else                           a = 64'($urandom_range(0, SIZE * 8 - 1));
            if ($urandom_range(0, 9) == 0) hold_next = 1'b1;
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), a, {$urandom, $urandom});
        end
        drain();

        for (int j = 0; j < SIZE; j++) checkOutput($sformatf("mem_entry_%0d", j), tbmem[j], ref_mem[j]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
